blood_fx_sequencer: RTL and testbench

- Controls the 64x64 blood-splatter sprite frame ROMs (12-bit RGB, 6-bit row/col address, 1-cycle registered-address latency).
- On a hit event it latches the splatter position and steps the ROM frame index at a fixed rate of video frames.
- For each pixel it drives the ROM row/col and returns an overlay colour and enable to the pixel mixer, compensating for the ROM latency.
- Sits between the game-logic hit detector and the VGA colour mux.

---
 rtl/blood_fx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_blood_fx_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/blood_fx_sequencer.sv
// Blood-splatter overlay sequencer: arms on a hit, steps the sprite ROM frame on video
// frame ticks, and produces a ROM-latency-aligned overlay colour/enable for the pixel mixer.
module blood_fx_sequencer #(
  parameter int          NUM_FRAMES      = 16,
  parameter int          TICKS_PER_FRAME = 3,
  parameter logic [11:0] TRANSPARENT     = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        hit,
  input  logic [9:0]  hit_x,
  input  logic [9:0]  hit_y,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [3:0]  rom_frame,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic        blood_on,
  output logic [11:0] blood_rgb,
  output logic        busy
);

  localparam int              TW         = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICKS_PER_FRAME - 1);
  localparam logic [3:0]      FRAME_LAST = 4'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     frame_q, frame_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [9:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]     pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic           pend_q, pend_d;
  logic           hit_d_q, hit_d_d;

  logic           play_s;
  logic           busy_s;
  logic           in_box_s;
  logic [10:0]    px_s, py_s, bx_s, by_s;

  // State register and ROM-latency alignment flop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      frame_q  <= 4'd0;
      tick_q   <= '0;
      pos_x_q  <= 10'd0;
      pos_y_q  <= 10'd0;
      pend_x_q <= 10'd0;
      pend_y_q <= 10'd0;
      pend_q   <= 1'b0;
      hit_d_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      tick_q   <= tick_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_q   <= pend_d;
      hit_d_q  <= hit_d_d;
    end
  end

  // Next-state: frame_tick consumes the old pending request, a same-cycle hit re-arms
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    tick_d   = tick_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_d   = pend_q;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED, S_PLAY: begin
        if (frame_tick && pend_q) begin
          state_d = S_PLAY;
          pos_x_d = pend_x_q;
          pos_y_d = pend_y_q;
          frame_d = 4'd0;
          tick_d  = '0;
          pend_d  = 1'b0;
        end else if (frame_tick && (state_q == S_PLAY)) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (frame_q == FRAME_LAST) begin
              frame_d = 4'd0;
              state_d = hit ? S_ARMED : S_IDLE;
            end else begin
              frame_d = frame_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (hit) begin
      pend_d   = 1'b1;
      pend_x_d = hit_x;
      pend_y_d = hit_y;
    end else begin
      pend_d   = pend_d;
    end
  end

  // FSM-derived outputs
  always_comb begin
    play_s = 1'b0;
    busy_s = pend_q;
    case (state_q)
      S_IDLE:  begin play_s = 1'b0; busy_s = pend_q; end
      S_ARMED: begin play_s = 1'b0; busy_s = 1'b1;   end
      S_PLAY:  begin play_s = 1'b1; busy_s = 1'b1;   end
      default: begin play_s = 1'b0; busy_s = pend_q; end
    endcase
  end

  // 11-bit box test so a sprite near x/y=1023 never wraps onto the left/top edge
  always_comb begin
    px_s     = {1'b0, pixel_x};
    py_s     = {1'b0, pixel_y};
    bx_s     = {1'b0, pos_x_q};
    by_s     = {1'b0, pos_y_q};
    in_box_s = (px_s >= bx_s) && (px_s < (bx_s + 11'd64)) &&
               (py_s >= by_s) && (py_s < (by_s + 11'd64));
    hit_d_d  = in_box_s & video_on & play_s;
  end

  assign rom_col   = pixel_x[5:0] - pos_x_q[5:0];
  assign rom_row   = pixel_y[5:0] - pos_y_q[5:0];
  assign rom_frame = frame_q;
  assign busy      = busy_s;
  assign blood_on  = hit_d_q & (rom_data != TRANSPARENT);
  assign blood_rgb = blood_on ? rom_data : 12'h000;

endmodule

// File: tb/tb_blood_fx_sequencer.sv
// Directed bench for blood_fx_sequencer with a tick-count reference model checked every cycle.
module tb_blood_fx_sequencer;
  localparam int NF  = 16;
  localparam int TPF = 3;

  logic        clk = 1'b0;
  logic        reset_n, frame_tick, hit, video_on;
  logic [9:0]  hit_x, hit_y, pixel_x, pixel_y;
  logic [11:0] rom_data;
  logic [3:0]  rom_frame;
  logic [5:0]  rom_row, rom_col;
  logic        blood_on, busy;
  logic [11:0] blood_rgb;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // reference model: animation described by ticks elapsed since the starting tick
  bit m_play, m_pend, m_vis;
  int m_n, m_px, m_py, m_qx, m_qy;

  blood_fx_sequencer dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .hit(hit),
    .hit_x(hit_x), .hit_y(hit_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .rom_frame(rom_frame), .rom_row(rom_row), .rom_col(rom_col),
    .rom_data(rom_data), .blood_on(blood_on), .blood_rgb(blood_rgb), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit inbox(input int px, input int py, input int bx, input int by);
    return (px >= bx) && (px < bx + 64) && (py >= by) && (py < by + 64);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_play = 0; m_pend = 0; m_vis = 0; m_n = 0;
      m_px = 0; m_py = 0; m_qx = 0; m_qy = 0;
    end else begin
      m_vis = m_play && video_on && inbox(int'(pixel_x), int'(pixel_y), m_px, m_py);
      if (frame_tick) begin
        if (m_pend) begin
          m_play = 1; m_n = 0; m_px = m_qx; m_py = m_qy; m_pend = 0;
        end else if (m_play) begin
          m_n++;
          if (m_n == NF * TPF) begin
            m_play = 0; m_n = 0;
          end
        end
      end
      if (hit) begin
        m_pend = 1; m_qx = int'(hit_x); m_qy = int'(hit_y);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_on;
      chk("rom_frame", 32'(rom_frame), m_play ? 32'(m_n / TPF) : 32'd0);
      chk("busy", 32'(busy), 32'(m_play || m_pend));
      exp_on = m_vis && (rom_data != 12'h000);
      chk("blood_on", 32'(blood_on), 32'(exp_on));
      chk("blood_rgb", 32'(blood_rgb), exp_on ? 32'(rom_data) : 32'd0);
      if (inbox(int'(pixel_x), int'(pixel_y), m_px, m_py)) begin
        chk("rom_col", 32'(rom_col), 32'((int'(pixel_x) - m_px) % 64));
        chk("rom_row", 32'(rom_row), 32'((int'(pixel_y) - m_py) % 64));
      end
    end
  end

  task automatic step(input logic h, input logic ft);
    hit = h;
    frame_tick = ft;
    @(posedge clk);
    #1;
    hit = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic probe(input string nm, input int px, input int py,
                       input logic [11:0] rd, input logic exp_on);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    video_on = 1'b1;
    step(1'b0, 1'b0);
    rom_data = rd;
    #1;
    chk(nm, 32'(blood_on), 32'(exp_on));
  endtask

  initial begin
    reset_n = 1'b0; hit = 1'b1; frame_tick = 1'b1; video_on = 1'b0;
    hit_x = 10'd0; hit_y = 10'd0; pixel_x = 10'd0; pixel_y = 10'd0; rom_data = 12'h000;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1; hit = 1'b0; frame_tick = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_blood_on", 32'(blood_on), 32'd0);
    chk("reset_frame", 32'(rom_frame), 32'd0);
    step(1'b0, 1'b1);
    chk("reset_idle_tick", 32'(busy), 32'd0);

    // basic play with addressing and box-edge probes
    hit_x = 10'd100; hit_y = 10'd200;
    step(1'b1, 1'b0);
    chk("armed_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b1);
    chk("start_frame", 32'(rom_frame), 32'd0);
    for (int k = 1; k <= NF * TPF; k++) begin
      pixel_x = 10'(97 + (k * 7) % 70);
      pixel_y = 10'(198 + k);
      video_on = 1'(k % 5 != 0);
      rom_data = (k % 2 == 0) ? 12'hE00 : 12'h000;
      step(1'b0, 1'b1);
      if (k == 2)  chk("frame_k2", 32'(rom_frame), 32'd0);
      if (k == 3)  chk("frame_k3", 32'(rom_frame), 32'd1);
      if (k == 47) chk("frame_k47", 32'(rom_frame), 32'd15);
      if (k == 48) begin
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_frame", 32'(rom_frame), 32'd0);
      end
      if (k == 10) begin
        pixel_x = 10'd137; pixel_y = 10'd205; video_on = 1'b1;
        #1;
        chk("addr_col", 32'(rom_col), 32'd37);
        chk("addr_row", 32'(rom_row), 32'd5);
        probe("lat_on", 137, 205, 12'hE00, 1'b1);
        chk("lat_rgb", 32'(blood_rgb), 32'hE00);
        rom_data = 12'h000; #1;
        chk("lat_transp", 32'(blood_on), 32'd0);
        probe("edge_x99", 99, 205, 12'hE00, 1'b0);
        probe("edge_x164", 164, 205, 12'hE00, 1'b0);
        probe("edge_x100", 100, 205, 12'hE00, 1'b1);
        probe("edge_x163", 163, 205, 12'h0F0, 1'b1);
        probe("edge_x163_t", 163, 205, 12'h000, 1'b0);
      end
    end

    // retrigger at frame 7
    hit_x = 10'd100; hit_y = 10'd200;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int k = 1; k <= 21; k++) step(1'b0, 1'b1);
    chk("retrig_f7", 32'(rom_frame), 32'd7);
    hit_x = 10'd300; hit_y = 10'd50;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("retrig_f0", 32'(rom_frame), 32'd0);
    probe("retrig_new", 300, 50, 12'hE00, 1'b1);
    probe("retrig_old", 100, 200, 12'hE00, 1'b0);
    for (int k = 1; k <= NF * TPF; k++) begin
      step(1'b0, 1'b1);
      if (k == 47) chk("retrig_k47", 32'(busy), 32'd1);
      if (k == 48) chk("retrig_end", 32'(busy), 32'd0);
    end

    // no wrap near x=1023
    hit_x = 10'd1000; hit_y = 10'd0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    probe("nowrap_x5", 5, 10, 12'hE00, 1'b0);
    probe("wrap_x1023", 1023, 10, 12'hE00, 1'b1);
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    reset_n = 1'b1;

    // hit coincident with frame_tick in IDLE, then reset mid-play
    hit_x = 10'd50; hit_y = 10'd60;
    step(1'b1, 1'b1);
    chk("sim_busy", 32'(busy), 32'd1);
    probe("sim_armed", 55, 65, 12'hE00, 1'b0);
    step(1'b0, 1'b1);
    probe("sim_play", 55, 65, 12'hE00, 1'b1);
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    chk("rst_mid_on", 32'(blood_on), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
